dram_cmd_queue: RTL

- Parametrised command buffer between the host-side request interface and the DRAM command scheduler.
- Accepts unpacked command fields over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Emits packed command words in the team's command-word layout, with widths generalised by parameter.
- Optionally splits a BL16 command into two BL8 commands. This is the mode the scheduler needs when it runs BL8-only.

---
 rtl/dram_cmd_pkg.sv | 49 ++++
 rtl/dram_cmd_queue_sync_fifo.sv | 77 +++++++
 rtl/dram_cmd_queue.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dram_cmd_pkg.sv
// Shared command-word definitions for the DRAM command queue: default field
// widths, burst-length encodings, split-phase states and a default-width packer.
package dram_cmd_pkg;

  localparam int ROW_W_D  = 13;
  localparam int COL_W_D  = 10;
  localparam int BANK_W_D = 3;

  localparam logic BL8  = 1'b0;
  localparam logic BL16 = 1'b1;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } split_phase_t;

  // Scheduler command word, MSB first; reserved bits are always zero.
  typedef struct packed {
    logic                r_w;
    logic                rsv0;
    logic [ROW_W_D-1:0]  row;
    logic                rsv1;
    logic                bl;
    logic                rsv2;
    logic                ap;
    logic [COL_W_D-1:0]  col;
    logic [BANK_W_D-1:0] bank;
  } command_t;

  function automatic command_t pack_cmd(
    input logic                r_w,
    input logic [ROW_W_D-1:0]  row,
    input logic                bl,
    input logic                ap,
    input logic [COL_W_D-1:0]  col,
    input logic [BANK_W_D-1:0] bank
  );
    command_t c;
    c      = '{default: 1'b0};
    c.r_w  = r_w;
    c.row  = row;
    c.bl   = bl;
    c.ap   = ap;
    c.col  = col;
    c.bank = bank;
    return c;
  endfunction

endpackage

// File: rtl/dram_cmd_queue_sync_fifo.sv
// Synchronous FIFO with combinational head read, occupancy count and a
// synchronous clear that behaves like reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (count_r == CNT_FULL);
  assign empty = (count_r == {(AW + 1){1'b0}});
  assign count = count_r;
  assign rdata = mem_r[rd_ptr_r];

  // Qualify requests against occupancy so callers cannot over/underflow.
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
  end

  // Storage; cleared so the head reads as zero after reset or clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Occupancy count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_r <= {(AW + 1){1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dram_cmd_queue.sv
// DRAM command queue: buffers host commands and emits packed scheduler words,
// optionally splitting each BL16 command into two BL8 beats.
module dram_cmd_queue
  import dram_cmd_pkg::*;
#(
  parameter int ROW_W    = ROW_W_D,
  parameter int COL_W    = COL_W_D,
  parameter int BANK_W   = BANK_W_D,
  parameter int DEPTH    = 8,
  parameter bit SPLIT_EN = 1'b1,
  localparam int CMD_W   = 6 + ROW_W + COL_W + BANK_W,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_r_w,
  input  logic [ROW_W-1:0]  in_row,
  input  logic [COL_W-1:0]  in_col,
  input  logic [BANK_W-1:0] in_bank,
  input  logic              in_bl,
  input  logic              in_ap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CMD_W-1:0]  out_cmd,
  output logic [CNT_W-1:0]  count,
  output logic              split_busy
);

  localparam int ENT_W = 3 + ROW_W + COL_W + BANK_W;
  localparam logic [COL_W-1:0] COL_STEP = COL_W'(4'd8);

  logic [ENT_W-1:0]  wr_ent_s;
  logic [ENT_W-1:0]  head_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              accept_s;
  logic              pop_entry_s;
  logic              split_head_s;
  logic              h_r_w_s;
  logic              h_bl_s;
  logic              h_ap_s;
  logic [ROW_W-1:0]  h_row_s;
  logic [COL_W-1:0]  h_col_s;
  logic [BANK_W-1:0] h_bank_s;
  logic [COL_W-1:0]  beat_col_s;
  logic              beat_bl_s;
  logic              beat_ap_s;
  split_phase_t      phase_r;
  split_phase_t      phase_nxt_s;

  assign wr_ent_s = {in_r_w, in_row, in_bl, in_ap, in_col, in_bank};
  assign {h_r_w_s, h_row_s, h_bl_s, h_ap_s, h_col_s, h_bank_s} = head_s;

  // A push in the flush cycle is dropped; the FIFO clear also wins over pops.
  assign push_s       = in_valid && !full_s && !flush;
  assign accept_s     = !empty_s && out_ready;
  assign split_head_s = SPLIT_EN && (h_bl_s == BL16);

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push_s),
    .pop   (pop_entry_s),
    .wdata (wr_ent_s),
    .rdata (head_s),
    .count (count),
    .full  (full_s),
    .empty (empty_s)
  );

  // Split phase register; rst and flush both return to the first beat.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      phase_r <= PH_A;
    end else begin
      phase_r <= phase_nxt_s;
    end
  end

  // Beat field selection and entry retirement for the current phase.
  always_comb begin
    phase_nxt_s = phase_r;
    pop_entry_s = 1'b0;
    beat_col_s  = h_col_s;
    beat_bl_s   = h_bl_s;
    beat_ap_s   = h_ap_s;
    case (phase_r)
      PH_A: begin
        if (split_head_s) begin
          // First half of a split: auto-precharge deferred to the second beat.
          beat_bl_s = BL8;
          beat_ap_s = 1'b0;
          if (accept_s) begin
            phase_nxt_s = PH_B;
          end else begin
            phase_nxt_s = PH_A;
          end
        end else begin
          pop_entry_s = accept_s;
        end
      end
      PH_B: begin
        beat_col_s = h_col_s + COL_STEP;
        beat_bl_s  = BL8;
        if (accept_s) begin
          pop_entry_s = 1'b1;
          phase_nxt_s = PH_A;
        end else begin
          phase_nxt_s = PH_B;
        end
      end
      default: begin
        phase_nxt_s = PH_A;
      end
    endcase
  end

  assign in_ready   = !full_s;
  assign out_valid  = !empty_s;
  assign split_busy = (phase_r == PH_B);
  assign out_cmd    = {h_r_w_s, 1'b0, h_row_s, 1'b0, beat_bl_s, 1'b0,
                       beat_ap_s, beat_col_s, h_bank_s};

endmodule
